dmem_banked_ctrl: RTL and testbench
===================================

# dmem_banked_ctrl

Parametrised, clocked successor to the team's 256x16 data memory. A single-port synchronous data memory with byte-enable writes, a req/ready handshake, a registered read with valid strobe, and a hardware clear sequence after reset. It sits between the CPU datapath (load/store unit) and the register file write-back, and replaces edge-on-control-signal access with a single clock domain.

## Interface
Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8
- ADDR_W, 8, address width; depth is 2**ADDR_W words
- BE_W, DATA_W/8, byte-enable width (derived, not overridden)

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  asynchronous active-low reset
- req  input  1  access request, qualified by ready
- ready  output  1  block accepts a request this cycle
- we  input  1  1 = write, 0 = read (sampled with req)
- be  input  BE_W  byte enables for writes, bit i = byte i
- address  input  ADDR_W  word address
- writeData  input  DATA_W  write data
- readData  output  DATA_W  registered read data
- readValid  output  1  one-cycle strobe: readData is new
- parityErr  output  1  parity mismatch on the current read (see Configuration)

## Operation
- States: INIT, RUN.
- Reset (asynchronous): state goes to INIT, clear counter = 0, ready = 0, readValid = 0, readData = 0, parityErr = 0.
- INIT: one word per cycle is written to all-zero (parity bits to 0), counter 0 to 2**ADDR_W-1. After the write of the last address, the next state is RUN. INIT lasts exactly 2**ADDR_W cycles. req is ignored, with no side effects.
- RUN: ready = 1 continuously. An access is accepted when req && ready.
- Accepted write: each byte i with be[i]=1 is updated at that clock edge. Other bytes are kept. be = 0 gives no change. readValid stays 0.
- Accepted read: readData = mem[address] is registered at the edge, and readValid = 1 for the following cycle only.
- readData holds its last value while readValid = 0.
- Back-to-back: one access per cycle, with no bubbles. A read of an address written in the previous cycle returns the new data.
- Reset mid-INIT or mid-RUN restarts INIT. Any in-flight readValid is dropped. Memory is cleared again.

## Timing
- Read latency: 1 cycle. The request is at edge N, and readData/readValid are valid after edge N, for cycle N+1.
- Write visibility: the write is at edge N. A read accepted at edge N+1 sees it.
- ready deasserts asynchronously on rst_n low. It reasserts 2**ADDR_W cycles after the first clk edge with rst_n high.
- All outputs are registered. There is no combinational path from req/address to readData.

## Configuration
- DMEM_PARITY_EN defined:
  - One even-parity bit is stored per byte and computed on each written byte.
  - On a read, stored parity is checked against the data.
  - parityErr = 1 in the same cycle as readValid if any byte mismatches. It is 0 otherwise.
- DMEM_PARITY_EN undefined:
  - No parity storage.
  - parityErr is tied to 0.
  - The port list is unchanged.

## Structure
- Package dmem_pkg:
  - state enum (INIT, RUN)
  - byte-parity function
  - BE_W derivation helper
- Sub-module dmem_init_seq: the INIT/RUN state machine plus the clear address counter. It outputs ready, init write enable and init address. The top muxes the init path against the user path into the storage array.

## Test plan
- Reset then idle, ADDR_W=8 -> ready = 0 for 256 cycles, then 1. A read of every address returns 0x0000.
- Write addr 0x10 data 0xBEEF be=2'b11, then read 0x10 next cycle -> readValid for 1 cycle, readData = 0xBEEF.
- Write 0x10 data 0x1234 be=2'b01 over 0xBEEF -> read returns 0xBE34. A write with be=2'b00 leaves it 0xBE34.
- Reads to 0x01, 0x02, 0x03 on consecutive cycles after writing 0xAAAA/0xBBBB/0xCCCC -> readValid high 3 cycles, data in order. readData holds 0xCCCC afterward.
- Assert rst_n low mid-read-burst -> readValid = 0 and readData = 0 immediately. Re-INIT occurs, and a read of 0x01 returns 0x0000. req during INIT has no effect.
- With DMEM_PARITY_EN, force-flip one stored data bit at 0x20 -> read of 0x20 gives parityErr = 1 with readValid. A clean address gives parityErr = 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and byte helpers for the banked data memory
package dmem_pkg;
  typedef enum logic {INIT, RUN} state_e;
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/dmem_init_seq.sv
// dmem_init_seq: INIT/RUN sequencer that sweeps every address once to clear memory after reset
module dmem_init_seq import dmem_pkg::*; #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready_o,
  output logic              init_we_o,
  output logic [ADDR_W-1:0] init_addr_o
);
  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ready_q;
  // Clear one word per cycle; leave INIT right after the last address is written
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == INIT) begin
      cnt_q <= cnt_q + ADDR_W'(1);
      if (&cnt_q) begin
        state_q <= RUN;
        ready_q <= 1'b1;
      end
    end
  assign ready_o     = ready_q;
  assign init_we_o   = state_q == INIT;
  assign init_addr_o = cnt_q;
endmodule

// File: rtl/dmem_banked_ctrl.sv
// dmem_banked_ctrl: single-port byte-enable data memory with registered read; DMEM_PARITY_EN adds per-byte even parity
module dmem_banked_ctrl import dmem_pkg::*; #(
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 8,
  localparam int BE_W   = be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  output logic              ready,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              readValid,
  output logic              parityErr
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic              wr, rd, perr_d;
  logic [DATA_W-1:0] readData_q;
  logic              readValid_q, parityErr_q;
  dmem_init_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .ready_o    (ready),
    .init_we_o  (init_we),
    .init_addr_o(init_addr)
  );
  assign wr = req && ready && we;
  assign rd = req && ready && !we;
  // Storage: the clear sweep owns the array during INIT, the user port only in RUN
  always_ff @(posedge clk)
    if (init_we) mem_q[init_addr] <= '0;
    else if (wr)
      for (int i = 0; i < BE_W; i++)
        if (be[i]) mem_q[address][8*i +: 8] <= writeData[8*i +: 8];
`ifdef DMEM_PARITY_EN
  logic [BE_W-1:0] par_q [DEPTH];
  // Parity shadow follows the same write rules as the data bytes
  always_ff @(posedge clk)
    if (init_we) par_q[init_addr] <= '0;
    else if (wr)
      for (int i = 0; i < BE_W; i++)
        if (be[i]) par_q[address][i] <= byte_par(writeData[8*i +: 8]);
  // Any byte whose recomputed parity disagrees with the stored bit flags the read
  always_comb begin
    perr_d = 1'b0;
    for (int i = 0; i < BE_W; i++)
      perr_d = perr_d | (byte_par(mem_q[address][8*i +: 8]) != par_q[address][i]);
  end
`else
  assign perr_d = 1'b0;
`endif
  // Registered read port: data holds between reads, valid and parity error are one-cycle strobes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      readData_q  <= '0;
      readValid_q <= 1'b0;
      parityErr_q <= 1'b0;
    end else begin
      readValid_q <= rd;
      parityErr_q <= rd && perr_d;
      if (rd) readData_q <= mem_q[address];
    end
  assign readData  = readData_q;
  assign readValid = readValid_q;
  assign parityErr = parityErr_q;
endmodule

// File: tb/tb_dmem_banked_ctrl.sv
// tb_dmem_banked_ctrl: directed plus random checks of the data memory against an array model
module tb_dmem_banked_ctrl;
  logic        clk = 1'b0, rst_n = 1'b1, req = 1'b0, we = 1'b0;
  logic [1:0]  be = '0;
  logic [7:0]  address = '0;
  logic [15:0] writeData = '0;
  logic        ready, readValid, parityErr;
  logic [15:0] readData;
  int          n_vec = 0, n_err = 0, edges = 0;
  logic [15:0] model [256];
  bit          corrupt [256];
  logic        m_ready = 1'b0, m_rv = 1'b0, m_pe = 1'b0;
  logic [15:0] m_rd = '0;

  dmem_banked_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ready(ready), .we(we), .be(be),
    .address(address), .writeData(writeData), .readData(readData),
    .readValid(readValid), .parityErr(parityErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_all(input string tag);
    chk({tag, ".valid"}, 16'(readValid), 16'(m_rv));
    chk({tag, ".data"}, readData, m_rd);
    chk({tag, ".ready"}, 16'(ready), 16'(m_ready));
    chk({tag, ".perr"}, 16'(parityErr), 16'(m_pe));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) begin
      model[i] = '0;
      corrupt[i] = 1'b0;
    end
    m_rv = 1'b0; m_rd = '0; m_ready = 1'b0; m_pe = 1'b0; edges = 0;
  endtask

  // One clock: drive, let the edge happen, advance the model, compare
  task automatic cyc(input logic r, input logic w, input logic [1:0] b,
                     input logic [7:0] a, input logic [15:0] d, input string tag);
    logic acc;
    req = r; we = w; be = b; address = a; writeData = d;
    acc = r && m_ready;
    @(posedge clk); #1;
    edges++;
    m_rv = acc && !w;
    m_pe = 1'b0;
    if (acc && w)
      for (int i = 0; i < 2; i++)
        if (b[i]) begin
          model[a][8*i +: 8] = d[8*i +: 8];
          if (i == 0) corrupt[a] = 1'b0;
        end
    if (m_rv) begin
      m_rd = model[a];
      m_pe = corrupt[a];
    end
    m_ready = edges >= 256;
    expect_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    clear_model();
    expect_all("rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    expect_all("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 256; i++)
      cyc(1'b1, 1'($urandom), 2'b11, 8'($urandom), 16'($urandom), "init");
    for (int i = 0; i < 256; i++) cyc(1'b1, 1'b0, 2'b00, 8'(i), '0, "clr");
    chk("clr_last", readData, 16'h0000);
    cyc(1'b1, 1'b1, 2'b11, 8'h10, 16'hBEEF, "wr_beef");
    cyc(1'b1, 1'b0, 2'b00, 8'h10, 16'h0, "rd_beef");
    chk("beef_lit", readData, 16'hBEEF);
    cyc(1'b0, 1'b0, 2'b00, 8'h00, 16'h0, "idle_hold");
    cyc(1'b1, 1'b1, 2'b01, 8'h10, 16'h1234, "wr_lo");
    cyc(1'b1, 1'b1, 2'b00, 8'h10, 16'hFFFF, "wr_none");
    cyc(1'b1, 1'b0, 2'b00, 8'h10, 16'h0, "rd_be34");
    chk("be34_lit", readData, 16'hBE34);
    cyc(1'b1, 1'b1, 2'b11, 8'h01, 16'hAAAA, "wr1");
    cyc(1'b1, 1'b1, 2'b11, 8'h02, 16'hBBBB, "wr2");
    cyc(1'b1, 1'b1, 2'b11, 8'h03, 16'hCCCC, "wr3");
    cyc(1'b1, 1'b0, 2'b00, 8'h01, 16'h0, "rd1");
    cyc(1'b1, 1'b0, 2'b00, 8'h02, 16'h0, "rd2");
    cyc(1'b1, 1'b0, 2'b00, 8'h03, 16'h0, "rd3");
    cyc(1'b0, 1'b0, 2'b00, 8'h00, 16'h0, "hold1");
    cyc(1'b0, 1'b1, 2'b11, 8'h03, 16'h0, "hold2");
    chk("hold_lit", readData, 16'hCCCC);
`ifdef DMEM_PARITY_EN
    cyc(1'b1, 1'b1, 2'b11, 8'h20, 16'h1111, "wr_p20");
    cyc(1'b1, 1'b1, 2'b11, 8'h21, 16'h5555, "wr_p21");
    dut.mem_q[32][0] = ~dut.mem_q[32][0];
    model[32][0] = ~model[32][0];
    corrupt[32] = 1'b1;
    cyc(1'b1, 1'b0, 2'b00, 8'h20, 16'h0, "rd_bad");
    chk("perr_lit", 16'(parityErr), 16'h1);
    cyc(1'b1, 1'b0, 2'b00, 8'h21, 16'h0, "rd_good");
`endif
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom_range(0, 15)), 16'($urandom), "rnd");
    cyc(1'b1, 1'b0, 2'b00, 8'h01, 16'h0, "burst1");
    cyc(1'b1, 1'b0, 2'b00, 8'h02, 16'h0, "burst2");
    do_reset();
    chk("rst_data_lit", readData, 16'h0000);
    for (int i = 0; i < 256; i++)
      cyc(1'b1, 1'b1, 2'b11, 8'h01, 16'($urandom) | 16'h1, "reinit");
    cyc(1'b1, 1'b0, 2'b00, 8'h01, 16'h0, "rd01_after");
    chk("rd01_lit", readData, 16'h0000);
    cyc(1'b0, 1'b0, 2'b00, 8'h00, 16'h0, "tail");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
